// File: rtl/tap_pkg.sv
// Shared types and constants for the Oric .TAP block loader.
package tap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HEADER,
    ST_NAME,
    ST_DATA,
    ST_DRAIN,
    ST_ERR
  } tap_state_e;

  localparam logic [7:0] TAP_SYNC_BYTE = 8'h16;
  localparam logic [7:0] TAP_MARK_BYTE = 8'h24;

  localparam int         HDR_LEN          = 9;
  localparam logic [3:0] HDR_IDX_TYPE     = 4'd2;
  localparam logic [3:0] HDR_IDX_AUTORUN  = 4'd3;
  localparam logic [3:0] HDR_IDX_END_HI   = 4'd4;
  localparam logic [3:0] HDR_IDX_END_LO   = 4'd5;
  localparam logic [3:0] HDR_IDX_START_HI = 4'd6;
  localparam logic [3:0] HDR_IDX_START_LO = 4'd7;
  localparam logic [3:0] HDR_IDX_LAST     = 4'(HDR_LEN - 1);

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } tap_wr_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tap_wr_fifo.sv
// Synchronous write FIFO with flush; push and pop may coincide, including while full.
module tap_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok) & ~flush;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tap_block_loader.sv
// Oric .TAP stream parser writing the program body to RAM through a small FIFO.
// Define TAP_MULTIBLOCK_EN to parse every block of a file instead of only the first.
module tap_block_loader
  import tap_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_MIN   = 3,
  parameter int NAME_MAX   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic        ram_gnt,
  output logic [15:0] loadpoint,
  output logic        tape_basic,
  output logic        tape_autorun,
  output logic        tape_complete,
  output logic        tape_error,
  output logic        busy
);

  localparam int          NW         = $clog2(NAME_MAX + 1);
  localparam logic [7:0]  SYNC_MIN_B = 8'(SYNC_MIN);
  localparam logic [NW-1:0] NAME_MAX_C = NW'(NAME_MAX);

  tap_state_e    state_q, state_d;
  logic          dl_q;
  logic [7:0]    sync_cnt_q, sync_cnt_d;
  logic [3:0]    hdr_idx_q, hdr_idx_d;
  logic [NW-1:0] name_cnt_q, name_cnt_d;
  logic          hdr_basic_q, hdr_basic_d;
  logic          hdr_auto_q, hdr_auto_d;
  logic [15:0]   end_addr_q, end_addr_d;
  logic [15:0]   start_addr_q, start_addr_d;
  logic [15:0]   addr_ctr_q, addr_ctr_d;
  logic [16:0]   remain_q, remain_d;
  logic [15:0]   loadpoint_q, loadpoint_d;
  logic          tape_basic_q, tape_basic_d;
  logic          tape_autorun_q, tape_autorun_d;
  logic          tape_complete_q, tape_complete_d;
  logic          tape_error_q, tape_error_d;

  logic          dl_rise, dl_fall, parsing;
  logic          fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  tap_wr_t       fifo_head, fifo_in;
  logic          unused_addr;

  assign unused_addr = ^ioctl_addr;
  assign dl_rise     = ioctl_download & ~dl_q;
  assign dl_fall     = ~ioctl_download & dl_q;
  assign parsing     = (state_q == ST_SYNC) || (state_q == ST_HEADER) ||
                       (state_q == ST_NAME) || (state_q == ST_DATA);
  assign fifo_pop    = ram_wr & ram_gnt;
  assign fifo_in     = '{addr: addr_ctr_q, data: ioctl_dout};

  tap_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(tap_wr_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head storage is unreset, so the RAM bus is forced to zero whenever nothing is queued.
  assign ram_wr        = ~fifo_empty;
  assign ram_addr      = fifo_empty ? 16'h0000 : fifo_head.addr;
  assign ram_dout      = fifo_empty ? 8'h00 : fifo_head.data;
  assign loadpoint     = loadpoint_q;
  assign tape_basic    = tape_basic_q;
  assign tape_autorun  = tape_autorun_q;
  assign tape_complete = tape_complete_q;
  assign tape_error    = tape_error_q;
  assign busy          = (state_q != ST_IDLE) || ~fifo_empty;

  always_comb begin
    state_d         = state_q;
    sync_cnt_d      = sync_cnt_q;
    hdr_idx_d       = hdr_idx_q;
    name_cnt_d      = name_cnt_q;
    hdr_basic_d     = hdr_basic_q;
    hdr_auto_d      = hdr_auto_q;
    end_addr_d      = end_addr_q;
    start_addr_d    = start_addr_q;
    addr_ctr_d      = addr_ctr_q;
    remain_d        = remain_q;
    loadpoint_d     = loadpoint_q;
    tape_basic_d    = tape_basic_q;
    tape_autorun_d  = tape_autorun_q;
    tape_complete_d = 1'b0;
    tape_error_d    = tape_error_q;
    fifo_flush      = 1'b0;
    fifo_push       = 1'b0;

    if (dl_rise) begin
      fifo_flush     = 1'b1;
      tape_error_d   = 1'b0;
      tape_basic_d   = 1'b0;
      tape_autorun_d = 1'b0;
      sync_cnt_d     = '0;
      state_d        = ST_SYNC;
    end else if (dl_fall && parsing) begin
      // Trailing padding after a complete block is not a truncation.
      if (state_q == ST_SYNC && sync_cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        state_d      = ST_ERR;
        tape_error_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_SYNC: if (ioctl_wr) begin
          if (ioctl_dout == TAP_SYNC_BYTE) begin
            sync_cnt_d = sat_inc8(sync_cnt_q);
          end else if (ioctl_dout == TAP_MARK_BYTE && sync_cnt_q >= SYNC_MIN_B) begin
            sync_cnt_d = '0;
            hdr_idx_d  = '0;
            state_d    = ST_HEADER;
          end else begin
            sync_cnt_d = '0;
          end
        end
        ST_HEADER: if (ioctl_wr) begin
          unique case (hdr_idx_q)
            HDR_IDX_TYPE:     hdr_basic_d        = (ioctl_dout == 8'h00);
            HDR_IDX_AUTORUN:  hdr_auto_d         = (ioctl_dout != 8'h00);
            HDR_IDX_END_HI:   end_addr_d[15:8]   = ioctl_dout;
            HDR_IDX_END_LO:   end_addr_d[7:0]    = ioctl_dout;
            HDR_IDX_START_HI: start_addr_d[15:8] = ioctl_dout;
            HDR_IDX_START_LO: start_addr_d[7:0]  = ioctl_dout;
            default: ;
          endcase
          if (hdr_idx_q == HDR_IDX_LAST) begin
            if (end_addr_q < start_addr_q) begin
              state_d      = ST_ERR;
              tape_error_d = 1'b1;
            end else begin
              addr_ctr_d = start_addr_q;
              remain_d   = {1'b0, end_addr_q} - {1'b0, start_addr_q} + 17'd1;
              name_cnt_d = '0;
              state_d    = ST_NAME;
            end
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end
        ST_NAME: if (ioctl_wr) begin
          if (ioctl_dout == 8'h00) begin
            state_d = ST_DATA;
          end else if (name_cnt_q == NAME_MAX_C) begin
            state_d      = ST_ERR;
            tape_error_d = 1'b1;
          end else begin
            name_cnt_d = name_cnt_q + 1'b1;
          end
        end
        ST_DATA: if (ioctl_wr) begin
          if (fifo_full && !fifo_pop) begin
            state_d      = ST_ERR;
            tape_error_d = 1'b1;
          end else begin
            fifo_push  = 1'b1;
            addr_ctr_d = addr_ctr_q + 16'd1;
            remain_d   = remain_q - 17'd1;
            if (remain_q == 17'd1) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: if (fifo_empty) begin
          loadpoint_d     = start_addr_q;
          tape_basic_d    = hdr_basic_q;
          tape_autorun_d  = hdr_auto_q;
          tape_complete_d = 1'b1;
`ifdef TAP_MULTIBLOCK_EN
          sync_cnt_d      = '0;
          state_d         = ioctl_download ? ST_SYNC : ST_IDLE;
`else
          state_d         = ST_IDLE;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      dl_q            <= 1'b0;
      sync_cnt_q      <= '0;
      hdr_idx_q       <= '0;
      name_cnt_q      <= '0;
      hdr_basic_q     <= 1'b0;
      hdr_auto_q      <= 1'b0;
      end_addr_q      <= '0;
      start_addr_q    <= '0;
      addr_ctr_q      <= '0;
      remain_q        <= '0;
      loadpoint_q     <= '0;
      tape_basic_q    <= 1'b0;
      tape_autorun_q  <= 1'b0;
      tape_complete_q <= 1'b0;
      tape_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      dl_q            <= ioctl_download;
      sync_cnt_q      <= sync_cnt_d;
      hdr_idx_q       <= hdr_idx_d;
      name_cnt_q      <= name_cnt_d;
      hdr_basic_q     <= hdr_basic_d;
      hdr_auto_q      <= hdr_auto_d;
      end_addr_q      <= end_addr_d;
      start_addr_q    <= start_addr_d;
      addr_ctr_q      <= addr_ctr_d;
      remain_q        <= remain_d;
      loadpoint_q     <= loadpoint_d;
      tape_basic_q    <= tape_basic_d;
      tape_autorun_q  <= tape_autorun_d;
      tape_complete_q <= tape_complete_d;
      tape_error_q    <= tape_error_d;
    end
  end

endmodule

// File: tb/tb_tap_block_loader.sv
// Directed bench for tap_block_loader: builds .TAP byte streams and scoreboards RAM writes.
module tb_tap_block_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic        ram_gnt;
  logic [15:0] loadpoint;
  logic        tape_basic, tape_autorun, tape_complete, tape_error, busy;

  int n_checks = 0;
  int n_errors = 0;

  int gnt_mode = 1;  // 0: hold low, 1: hold high, 2: toggle every cycle
  int cyc = 0;
  int n_pulse = 0;
  int pulse_cyc = 0;
  int last_wr_cyc = 0;

  logic [15:0] obs_addr[$];
  logic [7:0]  obs_data[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [15:0] lp_seen[$];
  logic [7:0]  stream[$];

  tap_block_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ram_addr       (ram_addr),
    .ram_dout       (ram_dout),
    .ram_wr         (ram_wr),
    .ram_gnt        (ram_gnt),
    .loadpoint      (loadpoint),
    .tape_basic     (tape_basic),
    .tape_autorun   (tape_autorun),
    .tape_complete  (tape_complete),
    .tape_error     (tape_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    ram_gnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0:       ram_gnt = 1'b0;
        1:       ram_gnt = 1'b1;
        default: ram_gnt = ~ram_gnt;
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (ram_wr && ram_gnt) begin
      obs_addr.push_back(ram_addr);
      obs_data.push_back(ram_dout);
      last_wr_cyc = cyc;
    end
    if (tape_complete) begin
      n_pulse++;
      pulse_cyc = cyc;
      lp_seen.push_back(loadpoint);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
    ioctl_addr = ioctl_addr + 25'd1;
    if (gap > 0) tick(gap);
  endtask

  task automatic play(input int gap);
    foreach (stream[i]) send_byte(stream[i], gap);
    stream.delete();
  endtask

  task automatic add_block(input int nsync, input logic [7:0] typ, input logic [7:0] aut,
                           input logic [15:0] s, input logic [15:0] e,
                           input int nname, input int ndata, input logic [7:0] base);
    for (int i = 0; i < nsync; i++) stream.push_back(8'h16);
    stream.push_back(8'h24);
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    stream.push_back(typ);
    stream.push_back(aut);
    stream.push_back(e[15:8]);
    stream.push_back(e[7:0]);
    stream.push_back(s[15:8]);
    stream.push_back(s[7:0]);
    stream.push_back(8'h00);
    for (int i = 0; i < nname; i++) stream.push_back(8'h41 + 8'(i));
    stream.push_back(8'h00);
    for (int i = 0; i < ndata; i++) stream.push_back(base + 8'(i * 17));
  endtask

  task automatic expect_writes(input logic [15:0] s, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(s + 16'(i));
      exp_data.push_back(base + 8'(i * 17));
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {8'h00, obs_addr[i], obs_data[i]},
            {8'h00, exp_addr[i], exp_data[i]});
  endtask

  task automatic begin_test();
    ioctl_download = 1'b0;
    gnt_mode       = 1;
    tick(3);
    obs_addr.delete();
    obs_data.delete();
    exp_addr.delete();
    exp_data.delete();
    lp_seen.delete();
    n_pulse    = 0;
    ioctl_addr = '0;
    ioctl_download = 1'b1;
    tick(2);
  endtask

  initial begin
    tick(3);
    check("rst_flags", 32'({ram_wr, tape_basic, tape_autorun, tape_complete, tape_error, busy}), 32'h0);
    check("rst_bus", {ram_addr, 8'h00, ram_dout}, 32'h0);
    check("rst_loadpoint", 32'(loadpoint), 32'h0);
    reset_n = 1'b1;
    tick(2);
    check("idle_busy", 32'(busy), 32'h0);

    // Happy path from the reference stream.
    begin_test();
    add_block(3, 8'h80, 8'hC7, 16'h4000, 16'h4003, 2, 4, 8'h11);
    play(1);
    tick(20);
    exp_addr = '{16'h4000, 16'h4001, 16'h4002, 16'h4003};
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_writes("happy");
    check("happy_pulses", 32'(n_pulse), 32'd1);
    check("happy_loadpoint", 32'(loadpoint), 32'h4000);
    check("happy_flags", 32'({tape_basic, tape_autorun, tape_error}), 32'b010);
    ioctl_download = 1'b0;
    tick(3);
    check("happy_idle", 32'(busy), 32'h0);

    // Two syncs are too few: the first marker is ignored.
    begin_test();
    stream = '{8'h16, 8'h16, 8'h24};
    add_block(4, 8'h00, 8'h00, 16'h1234, 16'h1236, 1, 3, 8'h11);
    play(1);
    tick(20);
    expect_writes(16'h1234, 3, 8'h11);
    check_writes("shortsync");
    check("shortsync_pulses", 32'(n_pulse), 32'd1);
    check("shortsync_loadpoint", 32'(loadpoint), 32'h1234);
    check("shortsync_flags", 32'({tape_basic, tape_autorun, tape_error}), 32'b100);

    // Overflow: no grants while six bytes arrive back to back.
    begin_test();
    gnt_mode = 0;
    add_block(3, 8'h00, 8'h01, 16'h2000, 16'h2005, 2, 6, 8'h11);
    play(0);
    tick(10);
    gnt_mode = 1;
    tick(20);
    expect_writes(16'h2000, 4, 8'h11);
    check_writes("ovf");
    check("ovf_error", 32'(tape_error), 32'h1);
    check("ovf_pulses", 32'(n_pulse), 32'd0);
    check("ovf_err_state_busy", 32'(busy), 32'h1);

    // Same stream with a toggling grant and bytes every third cycle.
    begin_test();
    check("restart_clears_error", 32'(tape_error), 32'h0);
    gnt_mode = 2;
    add_block(3, 8'h00, 8'h01, 16'h2000, 16'h2005, 2, 6, 8'h11);
    play(2);
    tick(30);
    expect_writes(16'h2000, 6, 8'h11);
    check_writes("toggle");
    check("toggle_pulses", 32'(n_pulse), 32'd1);
    check("toggle_pulse_after_last_wr", 32'(pulse_cyc > last_wr_cyc), 32'h1);
    check("toggle_flags", 32'({tape_basic, tape_autorun, tape_error}), 32'b110);
    check("toggle_loadpoint", 32'(loadpoint), 32'h2000);

    // Truncated file: download drops after two of four data bytes.
    begin_test();
    add_block(3, 8'h00, 8'h00, 16'h3000, 16'h3003, 2, 4, 8'h11);
    void'(stream.pop_back());
    void'(stream.pop_back());
    play(1);
    ioctl_download = 1'b0;
    tick(20);
    expect_writes(16'h3000, 2, 8'h11);
    check_writes("trunc");
    check("trunc_error", 32'(tape_error), 32'h1);
    check("trunc_pulses", 32'(n_pulse), 32'd0);
    ioctl_download = 1'b1;
    tick(2);
    check("trunc_restart_clears", 32'(tape_error), 32'h0);

    // End address below start address.
    begin_test();
    add_block(3, 8'h00, 8'h00, 16'h4000, 16'h3FFF, 1, 3, 8'h11);
    play(1);
    tick(20);
    check_writes("endlt");
    check("endlt_error", 32'(tape_error), 32'h1);
    check("endlt_pulses", 32'(n_pulse), 32'd0);

    // Seventeen-character filename overruns the name field.
    begin_test();
    add_block(3, 8'h00, 8'h00, 16'h5000, 16'h5001, 17, 2, 8'h11);
    play(1);
    tick(20);
    check_writes("longname");
    check("longname_error", 32'(tape_error), 32'h1);

    // Two concatenated blocks; the first uses a maximum-length name.
    begin_test();
    add_block(3, 8'h00, 8'h00, 16'h0501, 16'h0502, 16, 2, 8'h11);
    add_block(5, 8'h00, 8'h01, 16'h9800, 16'h9801, 1, 2, 8'hA0);
    play(1);
    tick(30);
    expect_writes(16'h0501, 2, 8'h11);
`ifdef TAP_MULTIBLOCK_EN
    expect_writes(16'h9800, 2, 8'hA0);
    check("multi_pulses", 32'(n_pulse), 32'd2);
    check("multi_lp1", (lp_seen.size() > 1) ? 32'(lp_seen[1]) : 32'hFFFF_FFFF, 32'h9800);
`else
    check("multi_pulses", 32'(n_pulse), 32'd1);
    check("multi_idle", 32'(busy), 32'h0);
`endif
    check_writes("multi");
    check("multi_lp0", (lp_seen.size() > 0) ? 32'(lp_seen[0]) : 32'hFFFF_FFFF, 32'h0501);
    check("multi_error", 32'(tape_error), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
